// File: rtl/sync_fifo_if.sv
// Push/pop handshake bundle between a producer/consumer and the sync_fifo storage.
interface sync_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  logic                     push;
  logic [WIDTH-1:0]         wdata;
  logic                     pop;
  logic [WIDTH-1:0]         rdata;
  logic                     full;
  logic                     almost_full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output push, wdata, pop,
    input  rdata, full, almost_full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, wdata, pop,
    output rdata, full, almost_full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and sticky
// overflow/underflow flags for dropped requests.
module sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic         clk,
  input  logic         rst,
  sync_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] AF_LVL  = AF_LEVEL[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full, empty, almost_full;
  logic             push_ok, pop_ok;
  logic [AW:0]      count;

  // Flags come straight from the registered pointers: the wrap bit
  // distinguishes a full ring from an empty one when the indices match.
  always_comb begin
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    count       = wptr_q - rptr_q;
    almost_full = (count >= AF_LVL);
  end

  always_comb begin
    pop_ok      = bus.pop & ~empty;
    push_ok     = bus.push & (~full | pop_ok);
    wptr_d      = push_ok ? wptr_q + PTR_ONE : wptr_q;
    rptr_d      = pop_ok  ? rptr_q + PTR_ONE : rptr_q;
    rdata_d     = pop_ok  ? mem_q[rptr_q[AW-1:0]] : rdata_q;
    overflow_d  = overflow_q  | (bus.push & ~push_ok);
    underflow_d = underflow_q | (bus.pop  & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= bus.wdata;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.full        = full;
  assign bus.almost_full = almost_full;
  assign bus.empty       = empty;
  assign bus.count       = count;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill/drain, overflow, push+pop at full,
// underflow without fall-through, pointer wrap and mid-stream reset.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0] q [$];
  logic [7:0] exp_rdata;

  sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

  sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      bus.push = 1'b1; bus.wdata = base + 8'(i); tick();
      check("fill_count", 32'(bus.count), 32'(i + 1));
      check("fill_af", 32'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
      check("fill_full", 32'(bus.full), (i == 7) ? 1 : 0);
      check("fill_empty", 32'(bus.empty), 0);
    end
    bus.push = 1'b0;
  endtask

  task automatic drain(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      bus.pop = 1'b1; tick();
      check("drain_rdata", 32'(bus.rdata), 32'(base) + 32'(i));
      check("drain_count", 32'(bus.count), 32'(7 - i));
      check("drain_full", 32'(bus.full), 0);
    end
    bus.pop = 1'b0;
    check("drain_empty", 32'(bus.empty), 1);
  endtask

  initial begin
    bus.push = 1'b1; bus.pop = 1'b1; bus.wdata = 8'h99; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_af", 32'(bus.almost_full), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_unf", 32'(bus.underflow), 0);

    fill(8'h10);
    drain(8'h10);

    // Overflow: rejected push leaves contents intact
    fill(8'h10);
    bus.push = 1'b1; bus.wdata = 8'hAA; tick(); bus.push = 1'b0;
    check("ovf_count", 32'(bus.count), 8);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_full", 32'(bus.full), 1);
    drain(8'h10);
    check("ovf_sticky", 32'(bus.overflow), 1);

    // Simultaneous push+pop at full
    do_reset();
    check("rst2_ovf", 32'(bus.overflow), 0);
    fill(8'h20);
    bus.push = 1'b1; bus.pop = 1'b1; bus.wdata = 8'h55; tick();
    bus.push = 1'b0; bus.pop = 1'b0;
    check("sim_rdata", 32'(bus.rdata), 32'h20);
    check("sim_count", 32'(bus.count), 8);
    check("sim_full", 32'(bus.full), 1);
    check("sim_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) begin
      bus.pop = 1'b1; tick();
      check("sim_drain", 32'(bus.rdata), (i == 7) ? 32'h55 : 32'h21 + 32'(i));
    end
    bus.pop = 1'b0;
    check("sim_empty", 32'(bus.empty), 1);

    // Underflow with simultaneous push: no fall-through
    bus.pop = 1'b1; bus.push = 1'b1; bus.wdata = 8'h3C; tick();
    bus.push = 1'b0;
    check("unf_flag", 32'(bus.underflow), 1);
    check("unf_rdata", 32'(bus.rdata), 32'h55);
    check("unf_count", 32'(bus.count), 1);
    check("unf_empty", 32'(bus.empty), 0);
    tick(); bus.pop = 1'b0;
    check("unf_pop", 32'(bus.rdata), 32'h3C);
    check("unf_count0", 32'(bus.count), 0);

    // Interleaved traffic across the pointer wrap against a queue model
    q.delete();
    exp_rdata = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      logic p_ok, w_ok;
      bus.push  = (i % 3 != 2);
      bus.pop   = (i % 2 == 1);
      bus.wdata = 8'h80 + 8'(i);
      p_ok = bus.pop && (q.size() > 0);
      w_ok = bus.push && ((q.size() < 8) || p_ok);
      if (p_ok) exp_rdata = q.pop_front();
      if (w_ok) q.push_back(bus.wdata);
      tick();
      check("wrap_rdata", 32'(bus.rdata), 32'(exp_rdata));
      check("wrap_count", 32'(bus.count), q.size());
    end
    bus.push = 1'b0; bus.pop = 1'b0;
    while (q.size() < 5) begin
      bus.push = 1'b1; bus.wdata = 8'hC0 + 8'(q.size()); q.push_back(bus.wdata); tick();
    end
    bus.push = 1'b0;
    while (q.size() > 5) begin
      bus.pop = 1'b1; exp_rdata = q.pop_front(); tick();
      check("trim_rdata", 32'(bus.rdata), 32'(exp_rdata));
    end
    bus.pop = 1'b0;
    check("pre_rst_count", 32'(bus.count), 5);

    // Mid-stream reset discards entries and clears sticky flags
    do_reset();
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_empty", 32'(bus.empty), 1);
    check("mrst_unf", 32'(bus.underflow), 0);
    check("mrst_ovf", 32'(bus.overflow), 0);
    check("mrst_rdata", 32'(bus.rdata), 0);
    bus.push = 1'b1; bus.wdata = 8'h77; tick();
    bus.wdata = 8'h78; bus.pop = 1'b1; tick();
    bus.push = 1'b0;
    check("post_rd0", 32'(bus.rdata), 32'h77);
    check("post_cnt1", 32'(bus.count), 1);
    tick(); bus.pop = 1'b0;
    check("post_rd1", 32'(bus.rdata), 32'h78);
    check("post_empty", 32'(bus.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
